// File: rtl/latch_if.sv
// latch_if: drive and return signals between the exerciser and the latch block under test.
interface latch_if;
   logic s;
   logic r;
   logic d;
   logic en;
   logic q1_in;
   logic q2_in;
   logic q3_in;
   modport master (output s, r, d, en, input q1_in, q2_in, q3_in);
   modport slave (input s, r, d, en, output q1_in, q2_in, q3_in);
endinterface

// File: rtl/latch_exerciser.sv
// latch_exerciser: sweeps 16 s/r/d/en vectors through an external latch block after an init step,
// checking synchronized q1..q3 against a reference model and recording the first failing step.
module latch_exerciser #(
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   latch_if.master          lb,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [4:0]       fail_vec,
   output logic [2:0]       fail_mask
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, INIT, DRIVE, SETTLE, CHECK, DONE} state_t;
   state_t state, next;
   logic [CW-1:0] cnt;
   logic [4:0] step, step_nxt;
   logic [3:0] drv, drv_nxt;
   logic [2:0] xp, xp_nxt, sync1, sync2, mism;
   logic ds, dr, dd, den;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE: next = start ? INIT : state;
         INIT, DRIVE: next = SETTLE;
         SETTLE: next = (cnt == CW'(1)) ? CHECK : SETTLE;
         CHECK: next = (step == 5'd15) ? DONE : DRIVE;
         default: next = IDLE;
      endcase
   end
   // step 16 is the init step, so the vector after it wraps to 0
   always_comb begin
      step_nxt = step[4] ? 5'd0 : step + 5'd1;
      drv_nxt = (next == INIT) ? 4'b0101 : (next == DRIVE) ? step_nxt[3:0] :
                (next == DONE) ? {2'b00, drv[1], 1'b0} : drv;
      {ds, dr, dd, den} = drv_nxt;
      xp_nxt = (next == INIT) ? 3'b000 :
               (next == DRIVE) ? {dr ? 1'b0 : ds ? 1'b1 : den ? dd : xp[2],
                                  dr ? 1'b0 : ds ? 1'b1 : xp[1],
                                  den ? dd : xp[0]} : xp;
      mism = sync2 ^ xp;
   end
   assign {lb.s, lb.r, lb.d, lb.en} = drv;
   assign pass = done && (err_count == '0);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         drv <= '0;
         xp <= '0;
         cnt <= '0;
         step <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err_count <= '0;
         fail_vec <= '0;
         fail_mask <= '0;
      end else begin
         sync1 <= {lb.q3_in, lb.q2_in, lb.q1_in};
         sync2 <= sync1;
         drv <= drv_nxt;
         xp <= xp_nxt;
         cnt <= (state == INIT || state == DRIVE) ? CW'(SETTLE_CYCLES) :
                (state == SETTLE) ? cnt - CW'(1) : cnt;
         step <= (next == INIT) ? 5'd16 : (next == DRIVE) ? step_nxt : step;
         if (next == INIT) begin
            busy <= 1'b1;
            done <= 1'b0;
            err_count <= '0;
            fail_vec <= '0;
            fail_mask <= '0;
         end else if (state == CHECK) begin
            if (mism != 3'b000) begin
               if (!(&err_count)) err_count <= err_count + 1'b1;
               if (err_count == '0) begin
                  fail_vec <= step;
                  fail_mask <= mism;
               end
            end
            if (next == DONE) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_latch_exerciser.sv
// tb_latch_exerciser: behavioural latch block with injectable stuck-at faults; sweep results
// predicted at start time into a scoreboard and compared when done rises.
module tb_latch_exerciser;
   typedef struct {int err; int fvec; int fmask; int pass;} exp_t;
   logic clk, reset_n, start, busy, done, pass;
   logic [7:0] err_count;
   logic [4:0] fail_vec;
   logic [2:0] fail_mask;
   logic lq1, lq2, lq3;
   int fault, checks, errors;
   exp_t sb[$];
   latch_if lb();
   latch_exerciser #(.SETTLE_CYCLES(4), .ERR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .lb(lb), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .fail_vec(fail_vec), .fail_mask(fail_mask)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always_latch if (lb.en) lq1 <= lb.d;
   always_latch begin
      if (lb.r) lq2 <= 1'b0;
      else if (lb.s) lq2 <= 1'b1;
   end
   always_latch begin
      if (lb.r) lq3 <= 1'b0;
      else if (lb.s) lq3 <= 1'b1;
      else if (lb.en) lq3 <= lb.d;
   end
   // fault 1: q2 stuck-at-0, fault 2: q1 stuck-at-1
   assign lb.q1_in = (fault == 2) ? 1'b1 : lq1;
   assign lb.q2_in = (fault == 1) ? 1'b0 : lq2;
   assign lb.q3_in = lq3;
   function automatic exp_t model(input int f);
      exp_t res;
      logic e1, e2, e3, vs, vr, vd, ve;
      logic [3:0] v;
      logic [2:0] m;
      res = '{0, 0, 0, 1};
      e1 = 1'b0;
      e2 = 1'b0;
      e3 = 1'b0;
      for (int k = 0; k < 17; k++) begin
         if (k > 0) begin
            v = 4'(k - 1);
            {vs, vr, vd, ve} = v;
            e1 = ve ? vd : e1;
            e2 = vr ? 1'b0 : vs ? 1'b1 : e2;
            e3 = vr ? 1'b0 : vs ? 1'b1 : ve ? vd : e3;
         end
         m = {1'b0, (f == 1) && e2, (f == 2) && !e1};
         if (m != 3'b000) begin
            if (res.err == 0) begin
               res.fvec = (k == 0) ? 16 : k - 1;
               res.fmask = int'(m);
            end
            res.err++;
         end
      end
      res.pass = (res.err == 0) ? 1 : 0;
      return res;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk(tag, {9'd0, busy, done, pass, err_count, fail_vec, fail_mask, lb.s, lb.r, lb.d, lb.en}, 0);
   endtask
   task automatic do_start();
      sb.push_back(model(fault));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int repulse);
      int n;
      bit busy_ok;
      exp_t e;
      n = 0;
      busy_ok = busy;
      while (!done && n < 300) begin
         if (n == repulse) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         n++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      chk({tag, "_latency"}, n, 102);
      chk({tag, "_busy"}, {31'd0, busy_ok}, 1);
      e = sb.pop_front();
      chk({tag, "_err_count"}, {24'd0, err_count}, e.err);
      chk({tag, "_fail_vec"}, {27'd0, fail_vec}, e.fvec);
      chk({tag, "_fail_mask"}, {29'd0, fail_mask}, e.fmask);
      chk({tag, "_pass"}, {31'd0, pass}, e.pass);
      chk({tag, "_done_drives"}, {28'd0, busy, lb.s, lb.r, lb.en}, 0);
   endtask
   initial begin
      checks = 0;
      errors = 0;
      fault = 0;
      start = 1'b0;
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      #1 chk_zero("reset_async");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk_zero("idle_no_start");
      do_start();
      wait_done("ideal", -1);
      fault = 1;
      do_start();
      wait_done("q2_sa0", -1);
      chk("q2_sa0_vec8", {27'd0, fail_vec}, 8);
      chk("q2_sa0_mask", {29'd0, fail_mask}, 3'b010);
      chk("q2_sa0_cnt4", {24'd0, err_count}, 4);
      fault = 2;
      do_start();
      wait_done("q1_sa1", -1);
      chk("q1_sa1_init", {27'd0, fail_vec}, 16);
      chk("q1_sa1_mask", {29'd0, fail_mask}, 3'b001);
      fault = 1;
      do_start();
      wait_done("repulse", 37);
      do_start();
      chk("restart_clear", {22'd0, busy, done, err_count}, 10'h200);
      wait_done("rerun", -1);
      fault = 0;
      do_start();
      repeat (45) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk_zero("reset_mid_sweep");
      sb.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1 chk_zero("post_reset_idle");
      do_start();
      wait_done("after_reset", -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
